// File: rtl/freq_pkg.sv
// rtl/freq_pkg.sv - shared frame constants and decoder state encoding
//
// Purpose : constants and types common to the frequency counter send stage
//           and the receive-side frame decoder.
// Contents: FRAME_HDR  - header byte that opens every result frame
//           FRAME_LEN  - total frame length in bytes (header + 4 payload)
//           state_t    - decoder state encoding (HUNT, B0..B3)
package freq_pkg;

    localparam logic [7:0] FRAME_HDR = 8'hFF;
    localparam int         FRAME_LEN = 5;

    typedef enum logic [2:0] {
        HUNT = 3'd0,
        B0   = 3'd1,
        B1   = 3'd2,
        B2   = 3'd3,
        B3   = 3'd4
    } state_t;

endpackage

// File: rtl/freq_gap_timer.sv
// rtl/freq_gap_timer.sv - idle-gap watchdog between payload bytes
//
// Purpose : counts idle cycles while a frame is in progress and flags when
//           the gap reaches TIMEOUT cycles.
// Ports   : baseClk    - clock, rising edge
//           hard_Clr_n - synchronous active-low reset
//           en         - frame in progress; counter held at 0 when low
//           clr        - a payload byte is accepted this cycle
//           expire     - one-cycle flag: this idle cycle is the TIMEOUT-th
module freq_gap_timer #(
    parameter int TIMEOUT = 50000,
    parameter int TO_W    = 16
) (
    input  logic baseClk,
    input  logic hard_Clr_n,
    input  logic en,
    input  logic clr,
    output logic expire
);

    // The counter holds the number of idle cycles already seen, so the
    // TIMEOUT-th idle cycle is the one that finds TIMEOUT-1 in the register.
    localparam logic [TO_W-1:0] LIMIT = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

    logic [TO_W-1:0] gap_q;
    logic [TO_W-1:0] gap_d;

    assign expire = (TIMEOUT != 0) && en && !clr && (gap_q == LIMIT);

    always_comb begin
        gap_d = gap_q;
        if (!en || clr || expire) begin
            gap_d = '0;
        end else if (gap_q != '1) begin
            // Saturate so a disabled timeout never wraps back to LIMIT.
            gap_d = gap_q + 1'b1;
        end
    end

    always_ff @(posedge baseClk) begin
        if (!hard_Clr_n) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end

endmodule

// File: rtl/freq_frame_decoder.sv
// rtl/freq_frame_decoder.sv - result frame decoder (0xFF header + 32-bit LE count)
//
// Purpose : hunts for the header byte, assembles the four following bytes
//           LSB first into a 32-bit count, and aborts stalled frames.
// Ports   : baseClk    - clock, rising edge
//           hard_Clr_n - synchronous active-low reset
//           rxData     - received byte, valid with rxValid
//           rxValid    - one-cycle byte strobe
//           count      - last good decoded count, held between frames
//           countValid - one-cycle pulse when count updates
//           frameErr   - one-cycle pulse when a frame times out
//           busy       - frame in progress (state other than HUNT)
//           frameCnt   - good frame counter, wraps at 8 bits
module freq_frame_decoder
    import freq_pkg::*;
#(
    parameter int TIMEOUT = 50000,
    parameter int TO_W    = 16
) (
    input  logic        baseClk,
    input  logic        hard_Clr_n,
    input  logic [7:0]  rxData,
    input  logic        rxValid,
    output logic [31:0] count,
    output logic        countValid,
    output logic        frameErr,
    output logic        busy,
    output logic [7:0]  frameCnt
);

    state_t            state_q, state_d;
    logic [2:0][7:0]   byte_q, byte_d;
    logic [31:0]       count_q, count_d;
    logic              count_valid_q, count_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              busy_q, busy_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;

    logic              gap_expire;
    logic              payload_accept;

    // Only payload bytes restart the gap; the header enters B0 with the
    // counter already at 0 because it is held clear while hunting.
    assign payload_accept = rxValid && (state_q != HUNT);

    freq_gap_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_gap_timer (
        .baseClk    (baseClk),
        .hard_Clr_n (hard_Clr_n),
        .en         (state_q != HUNT),
        .clr        (payload_accept),
        .expire     (gap_expire)
    );

    always_comb begin
        state_d       = state_q;
        byte_d        = byte_q;
        count_d       = count_q;
        count_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        frame_cnt_d   = frame_cnt_q;

        case (state_q)
            HUNT: begin
                if (rxValid && (rxData == FRAME_HDR)) begin
                    state_d = B0;
                end
            end
            B0: begin
                if (rxValid) begin
                    byte_d[0] = rxData;
                    state_d   = B1;
                end else if (gap_expire) begin
                    state_d     = HUNT;
                    frame_err_d = 1'b1;
                end
            end
            B1: begin
                if (rxValid) begin
                    byte_d[1] = rxData;
                    state_d   = B2;
                end else if (gap_expire) begin
                    state_d     = HUNT;
                    frame_err_d = 1'b1;
                end
            end
            B2: begin
                if (rxValid) begin
                    byte_d[2] = rxData;
                    state_d   = B3;
                end else if (gap_expire) begin
                    state_d     = HUNT;
                    frame_err_d = 1'b1;
                end
            end
            B3: begin
                if (rxValid) begin
                    // Top byte goes straight into the result; no need to stage it.
                    count_d       = {rxData, byte_q[2], byte_q[1], byte_q[0]};
                    count_valid_d = 1'b1;
                    frame_cnt_d   = frame_cnt_q + 8'd1;
                    state_d       = HUNT;
                end else if (gap_expire) begin
                    state_d     = HUNT;
                    frame_err_d = 1'b1;
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase

        busy_d = (state_d != HUNT);
    end

    always_ff @(posedge baseClk) begin
        if (!hard_Clr_n) begin
            state_q       <= HUNT;
            byte_q        <= '0;
            count_q       <= '0;
            count_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            busy_q        <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            byte_q        <= byte_d;
            count_q       <= count_d;
            count_valid_q <= count_valid_d;
            frame_err_q   <= frame_err_d;
            busy_q        <= busy_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign count      = count_q;
    assign countValid = count_valid_q;
    assign frameErr   = frame_err_q;
    assign busy       = busy_q;
    assign frameCnt   = frame_cnt_q;

endmodule

// File: doc/freq_frame_decoder.md
# freq_frame_decoder

Receive-side decoder for the measurement result frame produced by the frequency counter's send stage. It accepts a byte stream from the link receiver as single-cycle `rxData`/`rxValid` strobes. It hunts for the 0xFF header and reassembles the following four bytes, least significant byte first, into the 32-bit base-clock count. The block presents the count with a one-cycle valid pulse, and it flags frames that stall mid-payload.

## Interface
- `TIMEOUT`, default 50000: maximum idle cycles allowed between payload bytes; 0 disables the timeout.
- `TO_W`, default 16: width of the gap counter; must satisfy TIMEOUT < 2^TO_W.
- `baseClk` input 1: sole clock, rising edge.
- `hard_Clr_n` input 1: reset, synchronous, active-low.
- `rxData` input 8: received byte, sampled only when `rxValid`=1.
- `rxValid` input 1: one-cycle strobe, one byte per strobe; may be high on consecutive cycles.
- `count` output 32: last successfully decoded base count; holds between frames.
- `countValid` output 1: one-cycle pulse when `count` is updated.
- `frameErr` output 1: one-cycle pulse when a frame is aborted by timeout.
- `busy` output 1: high while a frame is in progress (any state other than HUNT).
- `frameCnt` output 8: number of good frames decoded; wraps 0xFF→0x00.

## Operation
- State machine: HUNT, B0, B1, B2, B3.
- HUNT:
  - `rxValid` with `rxData`=0xFF → B0.
  - Any other byte is discarded and the state stays HUNT.
- Bn (n=0..3): `rxValid` stores `rxData` into shift byte n.
  - Byte 0 is bits [7:0]; byte 3 is bits [31:24].
  - The state then advances B0→B1→B2→B3→HUNT.
- Inside B0..B3, 0xFF is ordinary data and never restarts the frame.
- On the byte accepted in B3:
  - `count` ← {b3,b2,b1,b0}.
  - `countValid` pulses.
  - `frameCnt` increments.
  - State → HUNT.
- A count value of 0 is accepted as valid.
- Gap timer, active in B0..B3 only:
  - Clears to 0 on entry to B0 and on every accepted payload byte.
  - Increments on every cycle without `rxValid`.
- Timeout abort, when the gap timer reaches TIMEOUT with no `rxValid` that cycle:
  - State → HUNT.
  - `frameErr` pulses.
  - Partial bytes are discarded; `count` and `frameCnt` are unchanged.
- Simultaneous timeout and `rxValid` in the same cycle: the byte is accepted and the timer clears; no error.
- Reset values:
  - State HUNT; gap timer 0; shift bytes 0.
  - `count`=0, `countValid`=0, `frameErr`=0, `busy`=0, `frameCnt`=0.
- Reset asserted mid-frame: at the next edge the block returns to HUNT with all reset values, and no `frameErr` pulse.

## Timing
- All outputs are registered.
- `countValid` goes high on the edge that samples the fourth payload byte's `rxValid`, i.e. visible the cycle after that strobe.
- `count` and `frameCnt` update on that same edge.
- `frameErr` is high for exactly one cycle, on the edge where the timer condition is met. `busy` drops on that same edge.
- `busy` rises on the edge that accepts the header and falls on the edge that accepts byte 3 or aborts.
- Throughput: back-to-back frames with `rxValid` held high for 10 consecutive cycles decode as 2 frames with no lost bytes.
- A header may directly follow the last payload byte on the next cycle.

## Structure
- Package `freq_pkg`:
  - `FRAME_HDR` = 8'hFF.
  - `FRAME_LEN` = 5.
  - State enumeration (HUNT, B0..B3), 3-bit encoding.
  - Shared by the send stage and this decoder.
- One sub-module, `freq_gap_timer`:
  - Parameterised by `TIMEOUT`/`TO_W`.
  - Inputs: `baseClk`, `hard_Clr_n`, enable (busy), clear (accepted byte).
  - Output: one-cycle expire.
  - TIMEOUT=0 ties expire low.
- The top level holds the FSM, the four-byte shift register, and the output registers.

## Test plan
- Frame FF 78 56 34 12, one byte every 8 cycles:
  - `count`=0x12345678.
  - `countValid` high one cycle after the 0x12 strobe.
  - `frameCnt`=1, `frameErr` never high.
- Noise then frame, 00 A5 3C FF 01 00 00 00:
  - `count`=0x00000001; the three noise bytes are ignored.
  - `busy` rises only after the 0xFF.
- Data equal to the header, FF FF FF FF FF on consecutive cycles:
  - `count`=0xFFFFFFFF, exactly one `countValid`.
  - A following FF 02 00 00 00 gives 0x00000002 and `frameCnt`=2.
- Timeout with TIMEOUT=20: send FF 11 22, then idle 20 cycles.
  - `frameErr` one-cycle pulse, `busy`→0, `count` unchanged.
  - Then FF 44 33 22 11 decodes to 0x11223344.
  - Repeat with a byte arriving exactly on cycle 20: no error.
- Reset mid-frame: send FF AA BB, then hold `hard_Clr_n`=0 for 1 cycle.
  - All outputs return to their reset values.
  - Following CC DD EE FF 01 00 00 00 gives `count`=0x00000001 and `frameCnt`=1.
- Wrap: decode 256 frames; `frameCnt` reads 0x00 after the last, with `countValid` pulses counted = 256.
